control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle control unit for the 16-bit Tron core. It fetches each instruction word from memory into an instruction register and decodes it. It then sequences the datapath through fetch, latch, execute and memory states by driving every datapath control input: register addresses, immediate, ALU/shift/bus selects, write strobes and PC controls. It sits directly upstream of the datapath and shares its memory read port.

## Interface
- No parameters; word width is fixed at 16 and the register file has 16 entries.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `memData` in 16: memory read data; synchronous read with 1-cycle latency.
- `instructionOp` out 8: `{IR[15:12], IR[7:4]}`.
- `immediate` out 16: extended immediate.
- `regAddA` out 4: source/address/target register, `IR[3:0]`.
- `regAddB` out 4: destination register and write address, `IR[11:8]`.
- `ALUOp` out 4, `shiftOp` out 2, `busOp` out 3, `flagOp` out 4.
- `immMUX` out 1: 1 selects `immediate`, 0 selects regA.
- `regWrite`, `memWrite`, `flagWrite`, `pcAdd`, `pcJump`, `pcBranch` out 1: strobes.
- `addrSel` out 1: 0 puts PC on the memory address, 1 puts regA on it.
- `halted` out 1: core stopped.

## Operation
- IR format: `[15:12]` opcode, `[11:8]` Rdest/cond, `[7:4]` ext, `[3:0]` Rsrc/Raddr. `imm8` is `IR[7:0]`.
- States:
  - FETCH: `addrSel`=0.
  - LATCH: IR <= `memData`.
  - EXEC: per-instruction controls.
  - MEM: LOAD only.
  - HALT: only with the macro enabled.
- Transitions: FETCH->LATCH->EXEC. EXEC->MEM for LOAD, EXEC->FETCH otherwise. MEM->FETCH.
- Outputs are Moore functions of (state, IR). In FETCH, LATCH and HALT, all strobes are 0.
- Decode in EXEC:
  - RTYPE `0x0`: `ALUOp`=ext, `immMUX`=0, `busOp`=ALU.
  - Immediate ALU: ADDI 5, SUBI 9, CMPI B, ANDI 1, ORI 2, XORI 3, MOVI D. `ALUOp`=opcode, `immMUX`=1.
  - Immediate extension: `imm8` is sign-extended for 5/9/B/D and zero-extended for 1/2/3.
  - Flags and writes: `flagWrite`=1 only for ADD/SUB/CMP (ext 5/9/B) and ADDI/SUBI/CMPI. `regWrite`=1 for all except CMP/CMPI.
  - Shift `0x8`:
    - ext 4 is LSH: `shiftOp`=00, `immMUX`=0.
    - ext 0 is LSHI left: `shiftOp`=01.
    - ext 1 is LSHI right: `shiftOp`=10.
    - LSHI amount is `{12'b0, IR[3:0]}` with `immMUX`=1.
    - `busOp`=SHIFT, `regWrite`=1.
  - LUI `0xF`: `immediate`=`{imm8, 8'h00}`, `busOp`=IMM, `regWrite`=1.
  - `0x4` group:
    - ext 0 LOAD: `addrSel`=1 in EXEC and MEM. In MEM, `busOp`=MEM, `regWrite`=1, `pcAdd`=1.
    - ext 4 STOR: `addrSel`=1, `memWrite`=1; data is regB.
    - ext C Jcond: `pcJump`=1, `flagOp`=cond.
    - ext 8 JAL: `busOp`=PC, `regWrite`=1, `pcJump`=1, `flagOp`=4'hE (always). The link value is the JAL address.
  - Bcond `0xC`: `immediate`=sign-extended `imm8`, `pcBranch`=1, `flagOp`=cond. The PC stage resolves taken/not-taken.
  - HALT `0x4`/ext 3: see Configuration.
- `pcAdd`=1 in the final cycle of every non-jump, non-branch instruction.
- Undefined encodings execute as NOP: EXEC with only `pcAdd`=1.

## Timing
- Reset: while `reset`=0, all strobes are forced to 0 combinationally. At the next edge, state becomes FETCH, IR becomes 16'h0000, and `halted` becomes 0. Reset in any state, including mid-LOAD, aborts the instruction with no register or memory write.
- Latency: LOAD takes 4 cycles. Every other instruction takes 3 cycles.
- Each strobe is asserted for exactly one cycle per instruction. `memWrite` and `regWrite` are never both high.
- IR changes only on the LATCH edge, so control outputs are stable throughout EXEC and MEM.

## Configuration
- `CTRL_HALT_EN` defined: HALT moves EXEC->HALT with no strobes. HALT holds until reset; `halted`=1 while in HALT.
- `CTRL_HALT_EN` undefined: HALT decodes as NOP, and `halted` is tied to 0.

## Structure
- Shared package `tron_ctrl_pkg` holds:
  - opcode/ext constants;
  - state enum: FETCH=0, LATCH=1, EXEC=2, MEM=3, HALT=4;
  - bus-select constants: ALU=0, SHIFT=1, IMM=2, MEM=3, PC=4.
- One sub-module, `instr_decode`: purely combinational, maps (state, IR) to all control outputs.
- `control_fsm` holds the state register and IR.

## Test plan
- Reset low mid-MEM of LOAD -> no `regWrite`; FETCH on the next edge; all strobes 0.
- ADDI R3 with `memData`=16'h5380 -> EXEC: `immediate`=16'hFF80, `ALUOp`=5, `immMUX`=1, `regWrite`=1, `flagWrite`=1, `pcAdd`=1, `regAddB`=3; 3 cycles total.
- LOAD `16'h4205` -> `addrSel`=1 for 2 cycles; MEM: `busOp`=3, `regWrite`=1, `regAddA`=5, `regAddB`=2; 4 cycles total.
- Bcond `16'hC0FE` -> `pcBranch`=1, `flagOp`=0, `immediate`=16'hFFFE, `pcAdd`=0.
- CMP `16'h01B2` -> `flagWrite`=1, `regWrite`=0.
- HALT `16'h4030` -> `halted`=1 stays until reset with macro; single-cycle `pcAdd` NOP without it.

Source files
------------

// File: rtl/tron_ctrl_pkg.sv
// Shared constants for the Tron control unit: opcode/ext encodings,
// controller states, bus-select codes and small decode helpers.
// Optional feature macro: CTRL_HALT_EN (see control_fsm).
package tron_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Primary opcodes, IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_MEMG  = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hF;

  // RTYPE ALU ext codes share numbering with the immediate opcodes
  localparam logic [3:0] EXT_AND  = 4'h1;
  localparam logic [3:0] EXT_OR   = 4'h2;
  localparam logic [3:0] EXT_XOR  = 4'h3;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_SUB  = 4'h9;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV  = 4'hD;

  // Shift group ext codes
  localparam logic [3:0] EXT_LSHI_L = 4'h0;
  localparam logic [3:0] EXT_LSHI_R = 4'h1;
  localparam logic [3:0] EXT_LSH    = 4'h4;

  // Memory/jump group ext codes
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_HALT  = 4'h3;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [3:0] COND_ALWAYS = 4'hE;

  // Datapath write-back bus selects
  localparam logic [2:0] BUS_ALU   = 3'd0;
  localparam logic [2:0] BUS_SHIFT = 3'd1;
  localparam logic [2:0] BUS_IMM   = 3'd2;
  localparam logic [2:0] BUS_MEM   = 3'd3;
  localparam logic [2:0] BUS_PC    = 3'd4;

  localparam logic [1:0] SH_REG   = 2'b00;
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

  function automatic logic is_load(input logic [15:0] ir);
    return (ir[15:12] == OP_MEMG) && (ir[7:4] == EXT_LOAD);
  endfunction

  function automatic logic is_halt(input logic [15:0] ir);
    return (ir[15:12] == OP_MEMG) && (ir[7:4] == EXT_HALT);
  endfunction

  // ALU operation codes that are actually implemented
  function automatic logic is_alu_code(input logic [3:0] code);
    return (code == EXT_AND) || (code == EXT_OR)  || (code == EXT_XOR) ||
           (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP) ||
           (code == EXT_MOV);
  endfunction

  // ALU operations that update the flag register
  function automatic logic is_flag_code(input logic [3:0] code);
    return (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP);
  endfunction

endpackage

// File: rtl/control_fsm_decode.sv
// instr_decode: combinational map from (state, IR) to every datapath
// control. Select-type outputs follow IR alone so they are stable across
// EXEC and MEM; strobes and addrSel are only raised in EXEC/MEM.
// HALT decoding depends on CTRL_HALT_EN.
import tron_ctrl_pkg::*;

module instr_decode (
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  output logic [15:0] immediate_o,
  output logic [3:0]  alu_op_o,
  output logic [1:0]  shift_op_o,
  output logic [2:0]  bus_op_o,
  output logic [3:0]  flag_op_o,
  output logic        imm_mux_o,
  output logic        reg_write_o,
  output logic        mem_write_o,
  output logic        flag_write_o,
  output logic        pc_add_o,
  output logic        pc_jump_o,
  output logic        pc_branch_o,
  output logic        addr_sel_o
);

  logic [3:0]  opc, ext, cond;
  logic [15:0] imm_sext, imm_zext;

  assign opc      = ir_i[15:12];
  assign cond     = ir_i[11:8];
  assign ext      = ir_i[7:4];
  assign imm_sext = {{8{ir_i[7]}}, ir_i[7:0]};
  assign imm_zext = {8'h00, ir_i[7:0]};

  // Strobes the instruction raises in its EXEC cycle, plus LOAD marker
  logic e_rw, e_mw, e_fw, e_pa, e_pj, e_pb, e_as, ld;

  // Instruction decode: selects and per-instruction strobe set
  always_comb begin
    immediate_o = imm_sext;
    alu_op_o    = 4'h0;
    shift_op_o  = SH_REG;
    bus_op_o    = BUS_ALU;
    flag_op_o   = 4'h0;
    imm_mux_o   = 1'b0;
    e_rw = 1'b0; e_mw = 1'b0; e_fw = 1'b0;
    e_pa = 1'b0; e_pj = 1'b0; e_pb = 1'b0;
    e_as = 1'b0; ld = 1'b0;
    case (opc)
      OP_RTYPE: begin
        e_pa = 1'b1;
        if (is_alu_code(ext)) begin
          alu_op_o = ext;
          e_fw     = is_flag_code(ext);
          e_rw     = (ext != EXT_CMP);
        end
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        immediate_o = imm_zext;
        alu_op_o    = opc;
        imm_mux_o   = 1'b1;
        e_rw = 1'b1; e_pa = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
        alu_op_o  = opc;
        imm_mux_o = 1'b1;
        e_fw = is_flag_code(opc);
        e_rw = (opc != OP_CMPI);
        e_pa = 1'b1;
      end
      OP_SHIFT: begin
        e_pa = 1'b1;
        if (ext == EXT_LSH || ext == EXT_LSHI_L || ext == EXT_LSHI_R) begin
          bus_op_o    = BUS_SHIFT;
          immediate_o = {12'h000, ir_i[3:0]};
          imm_mux_o   = (ext != EXT_LSH);
          shift_op_o  = (ext == EXT_LSH)    ? SH_REG :
                        (ext == EXT_LSHI_L) ? SH_LEFT : SH_RIGHT;
          e_rw = 1'b1;
        end
      end
      OP_LUI: begin
        immediate_o = {ir_i[7:0], 8'h00};
        bus_op_o    = BUS_IMM;
        e_rw = 1'b1; e_pa = 1'b1;
      end
      OP_MEMG: begin
        case (ext)
          EXT_LOAD: begin
            bus_op_o = BUS_MEM;
            e_as = 1'b1; ld = 1'b1;
          end
          EXT_STOR: begin
            e_as = 1'b1; e_mw = 1'b1; e_pa = 1'b1;
          end
          EXT_JCOND: begin
            flag_op_o = cond;
            e_pj = 1'b1;
          end
          EXT_JAL: begin
            bus_op_o  = BUS_PC;
            flag_op_o = COND_ALWAYS;
            e_rw = 1'b1; e_pj = 1'b1;
          end
`ifdef CTRL_HALT_EN
          EXT_HALT: ;
`endif
          default: e_pa = 1'b1;
        endcase
      end
      OP_BCOND: begin
        flag_op_o = cond;
        e_pb = 1'b1;
      end
      default: e_pa = 1'b1;
    endcase
  end

  // Gate strobes by state: EXEC uses the decoded set, MEM finishes LOAD
  always_comb begin
    reg_write_o  = 1'b0;
    mem_write_o  = 1'b0;
    flag_write_o = 1'b0;
    pc_add_o     = 1'b0;
    pc_jump_o    = 1'b0;
    pc_branch_o  = 1'b0;
    addr_sel_o   = 1'b0;
    case (state_i)
      ST_EXEC: begin
        reg_write_o  = e_rw;
        mem_write_o  = e_mw;
        flag_write_o = e_fw;
        pc_add_o     = e_pa;
        pc_jump_o    = e_pj;
        pc_branch_o  = e_pb;
        addr_sel_o   = e_as;
      end
      ST_MEM: begin
        reg_write_o = ld;
        pc_add_o    = ld;
        addr_sel_o  = ld;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle controller for the 16-bit Tron core. Holds the
// sequencing state and instruction register; all control outputs come from
// instr_decode. Strobes are forced low while reset is asserted.
// Macro CTRL_HALT_EN: when defined, HALT (0x4/ext 3) parks the core in
// HALT until reset; otherwise it executes as a NOP and halted is tied 0.
//
// state | meaning
// FETCH | PC drives memory address, read issued
// LATCH | read data returns, IR loaded at end of cycle
// EXEC  | instruction controls driven from IR
// MEM   | LOAD write-back of memory data
// HALT  | core stopped (CTRL_HALT_EN only)
import tron_ctrl_pkg::*;

module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memData,
  output logic [7:0]  instructionOp,
  output logic [15:0] immediate,
  output logic [3:0]  regAddA,
  output logic [3:0]  regAddB,
  output logic [3:0]  ALUOp,
  output logic [1:0]  shiftOp,
  output logic [2:0]  busOp,
  output logic [3:0]  flagOp,
  output logic        immMUX,
  output logic        regWrite,
  output logic        memWrite,
  output logic        flagWrite,
  output logic        pcAdd,
  output logic        pcJump,
  output logic        pcBranch,
  output logic        addrSel,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic dec_rw, dec_mw, dec_fw, dec_pa, dec_pj, dec_pb;

  // State and instruction register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state sequencing; IR only reloads on the LATCH edge
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        ir_d    = memData;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_load(ir_q))
          state_d = ST_MEM;
`ifdef CTRL_HALT_EN
        else if (is_halt(ir_q))
          state_d = ST_HALT;
`endif
        else
          state_d = ST_FETCH;
      end
      ST_MEM: state_d = ST_FETCH;
`ifdef CTRL_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  instr_decode u_decode (
    .state_i      (state_q),
    .ir_i         (ir_q),
    .immediate_o  (immediate),
    .alu_op_o     (ALUOp),
    .shift_op_o   (shiftOp),
    .bus_op_o     (busOp),
    .flag_op_o    (flagOp),
    .imm_mux_o    (immMUX),
    .reg_write_o  (dec_rw),
    .mem_write_o  (dec_mw),
    .flag_write_o (dec_fw),
    .pc_add_o     (dec_pa),
    .pc_jump_o    (dec_pj),
    .pc_branch_o  (dec_pb),
    .addr_sel_o   (addrSel)
  );

  assign instructionOp = {ir_q[15:12], ir_q[7:4]};
  assign regAddA       = ir_q[3:0];
  assign regAddB       = ir_q[11:8];

  // A reset mid-instruction must not let a write escape in that cycle
  assign regWrite  = reset & dec_rw;
  assign memWrite  = reset & dec_mw;
  assign flagWrite = reset & dec_fw;
  assign pcAdd     = reset & dec_pa;
  assign pcJump    = reset & dec_pj;
  assign pcBranch  = reset & dec_pb;

`ifdef CTRL_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed testbench for control_fsm with hand-computed expectations.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] memData = 16'h0000;
  logic [7:0]  instructionOp;
  logic [15:0] immediate;
  logic [3:0]  regAddA, regAddB, ALUOp, flagOp;
  logic [1:0]  shiftOp;
  logic [2:0]  busOp;
  logic        immMUX, regWrite, memWrite, flagWrite;
  logic        pcAdd, pcJump, pcBranch, addrSel, halted;

  int n_checks = 0;
  int n_errors = 0;

  control_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .memData       (memData),
    .instructionOp (instructionOp),
    .immediate     (immediate),
    .regAddA       (regAddA),
    .regAddB       (regAddB),
    .ALUOp         (ALUOp),
    .shiftOp       (shiftOp),
    .busOp         (busOp),
    .flagOp        (flagOp),
    .immMUX        (immMUX),
    .regWrite      (regWrite),
    .memWrite      (memWrite),
    .flagWrite     (flagWrite),
    .pcAdd         (pcAdd),
    .pcJump        (pcJump),
    .pcBranch      (pcBranch),
    .addrSel       (addrSel),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // {regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch}
  logic [5:0] strobes;
  assign strobes = {regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present the word, step through LATCH and stop in EXEC
  task automatic start_instr(input string tag, input logic [15:0] w);
    memData = w;
    chk({tag, ".fetch_str"}, {26'd0, strobes}, 32'h0);
    chk({tag, ".fetch_as"}, {31'd0, addrSel}, 32'h0);
    tick();
    chk({tag, ".latch_str"}, {26'd0, strobes}, 32'h0);
    tick();
    chk({tag, ".iop"}, {24'd0, instructionOp}, {24'd0, w[15:12], w[7:4]});
  endtask

  // After the final cycle: must be back in FETCH (quiet, PC address)
  task automatic finish_instr(input string tag);
    tick();
    chk({tag, ".end_str"}, {26'd0, strobes}, 32'h0);
    chk({tag, ".end_as"}, {31'd0, addrSel}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    tick(); tick();
    chk("rst.str", {26'd0, strobes}, 32'h0);
    chk("rst.iop", {24'd0, instructionOp}, 32'h0);
    chk("rst.halted", {31'd0, halted}, 32'h0);
    reset = 1'b1;

    // ADDI R3, -128 : 3 cycles
    start_instr("addi", 16'h5380);
    chk("addi.imm", {16'd0, immediate}, 32'hFF80);
    chk("addi.alu", {28'd0, ALUOp}, 32'h5);
    chk("addi.mux", {31'd0, immMUX}, 32'h1);
    chk("addi.bus", {29'd0, busOp}, 32'h0);
    chk("addi.str", {26'd0, strobes}, 32'b101100);
    chk("addi.rb", {28'd0, regAddB}, 32'h3);
    finish_instr("addi");

    // LOAD R2 <- [R5] : 4 cycles, addrSel in EXEC and MEM
    start_instr("load", 16'h4205);
    chk("load.ex_as", {31'd0, addrSel}, 32'h1);
    chk("load.ex_str", {26'd0, strobes}, 32'h0);
    tick();
    chk("load.mem_as", {31'd0, addrSel}, 32'h1);
    chk("load.mem_bus", {29'd0, busOp}, 32'h3);
    chk("load.mem_str", {26'd0, strobes}, 32'b100100);
    chk("load.ra", {28'd0, regAddA}, 32'h5);
    chk("load.rb", {28'd0, regAddB}, 32'h2);
    finish_instr("load");

    // Bcond cond 0, offset -2
    start_instr("bcond", 16'hC0FE);
    chk("bcond.str", {26'd0, strobes}, 32'b000001);
    chk("bcond.flag", {28'd0, flagOp}, 32'h0);
    chk("bcond.imm", {16'd0, immediate}, 32'hFFFE);
    finish_instr("bcond");

    // CMP R1, R2: flags only
    start_instr("cmp", 16'h01B2);
    chk("cmp.str", {26'd0, strobes}, 32'b001100);
    chk("cmp.alu", {28'd0, ALUOp}, 32'hB);
    chk("cmp.mux", {31'd0, immMUX}, 32'h0);
    finish_instr("cmp");

    // ANDI zero-extends
    start_instr("andi", 16'h1385);
    chk("andi.imm", {16'd0, immediate}, 32'h0085);
    chk("andi.alu", {28'd0, ALUOp}, 32'h1);
    chk("andi.str", {26'd0, strobes}, 32'b100100);
    finish_instr("andi");

    // LSHI right by 2
    start_instr("lshi", 16'h8312);
    chk("lshi.sh", {30'd0, shiftOp}, 32'h2);
    chk("lshi.imm", {16'd0, immediate}, 32'h0002);
    chk("lshi.mux", {31'd0, immMUX}, 32'h1);
    chk("lshi.bus", {29'd0, busOp}, 32'h1);
    chk("lshi.str", {26'd0, strobes}, 32'b100100);
    finish_instr("lshi");

    // LSH by register
    start_instr("lsh", 16'h8347);
    chk("lsh.sh", {30'd0, shiftOp}, 32'h0);
    chk("lsh.mux", {31'd0, immMUX}, 32'h0);
    finish_instr("lsh");

    // LUI
    start_instr("lui", 16'hF2AB);
    chk("lui.imm", {16'd0, immediate}, 32'hAB00);
    chk("lui.bus", {29'd0, busOp}, 32'h2);
    chk("lui.str", {26'd0, strobes}, 32'b100100);
    finish_instr("lui");

    // STOR
    start_instr("stor", 16'h4446);
    chk("stor.as", {31'd0, addrSel}, 32'h1);
    chk("stor.str", {26'd0, strobes}, 32'b010100);
    finish_instr("stor");

    // JAL
    start_instr("jal", 16'h4E83);
    chk("jal.bus", {29'd0, busOp}, 32'h4);
    chk("jal.flag", {28'd0, flagOp}, 32'hE);
    chk("jal.str", {26'd0, strobes}, 32'b100010);
    finish_instr("jal");

    // Jcond cond 1
    start_instr("jcond", 16'h41C7);
    chk("jcond.flag", {28'd0, flagOp}, 32'h1);
    chk("jcond.str", {26'd0, strobes}, 32'b000010);
    finish_instr("jcond");

    // Undefined opcode executes as NOP
    start_instr("undef", 16'h7000);
    chk("undef.str", {26'd0, strobes}, 32'b000100);
    finish_instr("undef");

    // Reset during MEM of a LOAD
    start_instr("ldrst", 16'h4105);
    tick();
    chk("ldrst.mem_str", {26'd0, strobes}, 32'b100100);
    reset = 1'b0;
    #1;
    chk("ldrst.rst_str", {26'd0, strobes}, 32'h0);
    tick();
    chk("ldrst.ir_clr", {24'd0, instructionOp}, 32'h0);
    chk("ldrst.str2", {26'd0, strobes}, 32'h0);
    reset = 1'b1;
    chk("ldrst.as", {31'd0, addrSel}, 32'h0);
    start_instr("post", 16'h5380);
    chk("post.str", {26'd0, strobes}, 32'b101100);
    finish_instr("post");

    // HALT
    start_instr("halt", 16'h4030);
`ifdef CTRL_HALT_EN
    chk("halt.ex_str", {26'd0, strobes}, 32'h0);
    memData = 16'h5380;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt.held", {31'd0, halted}, 32'h1);
      chk("halt.str", {26'd0, strobes}, 32'h0);
    end
    reset = 1'b0;
    tick();
    chk("halt.rst", {31'd0, halted}, 32'h0);
    reset = 1'b1;
`else
    chk("halt.nop_str", {26'd0, strobes}, 32'b000100);
    chk("halt.halted", {31'd0, halted}, 32'h0);
    finish_instr("halt");
    chk("halt.halted2", {31'd0, halted}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
